sdram_memtest_master: RTL and testbench

SDRAM_MEMTEST_MASTER -- requirements
Module: sdram_memtest_master

---
 rtl/sdram_memtest_pkg.sv | 21 ++
 rtl/memtest_pattern_gen.sv | 31 +++
 rtl/sdram_memtest_master.sv | 159 +++++++++++++++
 tb/tb_sdram_memtest_master.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_memtest_pkg.sv
// Shared definitions for the SDRAM memory-test master: FSM states,
// default read depth and the test-pattern function.
package sdram_memtest_pkg;

  localparam int MAX_RD_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Word i carries i XOR seed; callers size-cast the result to their data width.
  function automatic logic [63:0] pattern_word(input logic [63:0] index,
                                               input logic [63:0] seed);
    return index ^ seed;
  endfunction

endpackage

// File: rtl/memtest_pattern_gen.sv
// Walks a word index from zero and produces the matching address
// (base + index, wrapping) and pattern data for that word.
module memtest_pattern_gen
  import sdram_memtest_pkg::*;
#(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
  input  logic [DATA_W-1:0] seed,
  output logic [ADDR_W-1:0] index,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n)       index <= '0;
    else if (clear)   index <= '0;
    else if (advance) index <= index + ADDR_W'(1);
  end

  assign addr = base + index;
  assign data = DATA_W'(pattern_word(64'(index), 64'(seed)));

endmodule

// File: rtl/sdram_memtest_master.sv
// Avalon-MM memory test master: writes a seeded pattern over a word range,
// reads it back with up to MAX_RD reads in flight, and counts mismatches.
module sdram_memtest_master
  import sdram_memtest_pkg::*;
#(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16,
  parameter int MAX_RD = MAX_RD_DEFAULT
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   length,
  input  logic [DATA_W-1:0]   seed,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_write,
  output logic                avm_read,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   first_err_addr
);

  localparam int OUT_W = $clog2(MAX_RD + 1);

  state_t            state;
  logic [ADDR_W-1:0] base_q, len_q;
  logic [DATA_W-1:0] seed_q;
  logic [ADDR_W-1:0] issue_idx, issue_addr, cmp_idx, cmp_addr;
  logic [DATA_W-1:0] issue_data, cmp_data;
  logic [OUT_W-1:0]  outstanding, outstanding_nxt;
  logic              start_ok, wr_acc, rd_acc, rd_valid, last_issue;

  assign start_ok   = ((state == ST_IDLE) || (state == ST_DONE)) && start;
  assign wr_acc     = avm_write && !avm_waitrequest;
  assign rd_acc     = avm_read && !avm_waitrequest;
  assign last_issue = (issue_idx == len_q - ADDR_W'(1));
  // Data beyond the last expected word can only be stale traffic from an aborted test.
  assign rd_valid   = avm_readdatavalid && (cmp_idx != len_q) &&
                      ((state == ST_READ) || (state == ST_DRAIN));

  memtest_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_issue_gen (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .clear   (start_ok || (wr_acc && last_issue)),
    .advance (wr_acc || rd_acc),
    .base    (base_q),
    .seed    (seed_q),
    .index   (issue_idx),
    .addr    (issue_addr),
    .data    (issue_data)
  );

  memtest_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cmp_gen (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .clear   (start_ok),
    .advance (rd_valid),
    .base    (base_q),
    .seed    (seed_q),
    .index   (cmp_idx),
    .addr    (cmp_addr),
    .data    (cmp_data)
  );

  // Index only moves on acceptance, so address/data hold across waitrequest.
  assign avm_address    = issue_addr;
  assign avm_writedata  = issue_data;
  assign avm_byteenable = (avm_write || avm_read) ? '1 : '0;

  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    outstanding_nxt = outstanding;
    if (rd_acc && !rd_valid)
      outstanding_nxt = outstanding + OUT_W'(1);
    else if (!rd_acc && rd_valid && (outstanding != '0))
      outstanding_nxt = outstanding - OUT_W'(1);
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state          <= ST_IDLE;
      avm_write      <= 1'b0;
      avm_read       <= 1'b0;
      outstanding    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      base_q         <= '0;
      len_q          <= '0;
      seed_q         <= '0;
    end else begin
      outstanding <= outstanding_nxt;

      if (rd_valid && (avm_readdata != cmp_data)) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == '0)       first_err_addr <= cmp_addr;
      end

      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            base_q         <= base_addr;
            len_q          <= length;
            seed_q         <= seed;
            err_count      <= '0;
            first_err_addr <= '0;
            if (length == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state     <= ST_WRITE;
              avm_write <= 1'b1;
              busy      <= 1'b1;
              done      <= 1'b0;
              pass      <= 1'b0;
            end
          end
        end
        ST_WRITE: begin
          if (wr_acc && last_issue) begin
            avm_write <= 1'b0;
            avm_read  <= 1'b1;
            state     <= ST_READ;
          end
        end
        ST_READ: begin
          if (rd_acc && last_issue) begin
            avm_read <= 1'b0;
            state    <= ST_DRAIN;
          end else if (!avm_read || rd_acc) begin
            avm_read <= (outstanding_nxt < OUT_W'(MAX_RD));
          end
        end
        ST_DRAIN: begin
          if ((outstanding == '0) && !avm_readdatavalid) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_memtest_master.sv
// Self-checking bench: behavioural Avalon slave with stalls, read latency and
// fault injection; results compared to an arithmetic model of the test.
module tb_sdram_memtest_master;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n, start;
  logic [ADDR_W-1:0] base_addr, length;
  logic [DATA_W-1:0] seed;
  logic [ADDR_W-1:0] avm_address, first_err_addr;
  logic              avm_write, avm_read, busy, done, pass;
  logic [DATA_W-1:0] avm_writedata;
  logic [1:0]        avm_byteenable;
  logic              waitrequest = 1'b0, rdv = 1'b0;
  logic [DATA_W-1:0] rdata = '0;
  logic [15:0]       err_count;

  always #5 clk = ~clk;

  sdram_memtest_master dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .start(start),
    .base_addr(base_addr), .length(length), .seed(seed),
    .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(waitrequest), .avm_readdata(rdata),
    .avm_readdatavalid(rdv), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  int passed = 0, total = 0, failed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural Avalon slave ----------------
  typedef struct { logic [ADDR_W-1:0] a; int due; } rd_t;

  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  rd_t               pipe[$];
  logic [ADDR_W-1:0] wr_a[$], rd_a[$];
  logic [DATA_W-1:0] wr_d[$];
  int  stall_mode = 0, latency = 2, cyc = 0, cmd_idx = 0, stall_left = 0, bench_out = 0;
  int  valid_cnt = 0, stable_viol = 0, overlap_viol = 0, maxout_viol = 0, early_viol = 0, be_viol = 0;
  bit  corrupt_en = 0, in_cmd = 0;
  logic [ADDR_W-1:0] corrupt_addr = '0;
  logic [ADDR_W+DATA_W+1:0] snap;

  always @(negedge clk) begin
    cyc++;
    rdv = 1'b0;
    if (!rst_n) in_cmd = 0;
    if (avm_write && avm_read) overlap_viol++;
    if (avm_read && bench_out >= 4) maxout_viol++;
    if (avm_write || avm_read) begin
      if (avm_byteenable !== 2'b11) be_viol++;
      if (!in_cmd) begin
        in_cmd = 1;
        cmd_idx++;
        snap = {avm_address, avm_writedata, avm_write, avm_read};
        case (stall_mode)
          1:       stall_left = (cmd_idx % 2 == 0) ? 3 : 0;
          2:       stall_left = $urandom_range(0, 3);
          default: stall_left = 0;
        endcase
      end else if ({avm_address, avm_writedata, avm_write, avm_read} !== snap) begin
        stable_viol++;
      end
      if (stall_left > 0) begin
        waitrequest = 1'b1;
        stall_left--;
      end else begin
        waitrequest = 1'b0;
        in_cmd = 0;
        if (avm_write) begin
          mem[avm_address] = avm_writedata;
          wr_a.push_back(avm_address);
          wr_d.push_back(avm_writedata);
        end else begin
          rd_a.push_back(avm_address);
          pipe.push_back('{avm_address, cyc + latency});
          bench_out++;
        end
      end
    end else begin
      if (in_cmd) stable_viol++;
      in_cmd = 0;
      waitrequest = 1'b0;
    end
    if (pipe.size() > 0 && pipe[0].due == cyc) begin
      rd_t e;
      e = pipe.pop_front();
      rdv = 1'b1;
      rdata = (mem.exists(e.a) ? mem[e.a] : '0) ^
              ((corrupt_en && e.a == corrupt_addr) ? 16'h0001 : 16'h0000);
      valid_cnt++;
      bench_out--;
      if (done) early_viol++;
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_obs(input int smode, input int lat, input bit cen, input logic [ADDR_W-1:0] caddr);
    stall_mode = smode; latency = lat; corrupt_en = cen; corrupt_addr = caddr;
    wr_a.delete(); wr_d.delete(); rd_a.delete();
    valid_cnt = 0; cmd_idx = 0;
    stable_viol = 0; overlap_viol = 0; maxout_viol = 0; early_viol = 0; be_viol = 0;
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n, input logic [DATA_W-1:0] s);
    @(negedge clk);
    start = 1'b1; base_addr = b; length = n; seed = s;
    @(negedge clk);
    start = 1'b0; base_addr = ADDR_W'($urandom); length = ADDR_W'($urandom); seed = DATA_W'($urandom);
  endtask

  task automatic reset_and_check(input string tag);
    rst_n = 1'b0;
    @(negedge clk);
    check({tag, "/write"}, avm_write, 0);
    check({tag, "/read"}, avm_read, 0);
    check({tag, "/address"}, avm_address, 0);
    check({tag, "/writedata"}, avm_writedata, 0);
    check({tag, "/status"}, {busy, done, pass}, 0);
    check({tag, "/err_count"}, err_count, 0);
    check({tag, "/first_err"}, first_err_addr, 0);
    rst_n = 1'b1;
  endtask

  task automatic run_test(input string name, input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n,
                          input logic [DATA_W-1:0] s, input int smode, input int lat,
                          input bit cen, input logic [ADDR_W-1:0] caddr, input bit poke);
    int exp_err, bad, cycles;
    logic [ADDR_W-1:0] exp_first, ea;
    logic [DATA_W-1:0] ed;
    clear_obs(smode, lat, cen, caddr);
    pulse_start(b, n, s);
    if (n == 0) begin
      check({name, "/done_now"}, {done, pass, busy}, 3'b110);
      repeat (3) @(negedge clk);
      check({name, "/no_cmds"}, cmd_idx, 0);
      return;
    end
    check({name, "/first_cmd"}, {avm_write, avm_read, busy, avm_address}, {3'b101, b});
    cycles = 0;
    while (!done && cycles < 5000) begin
      @(negedge clk);
      cycles++;
      if (poke && cycles == 20) begin
        start = 1'b1; base_addr = '0; length = '0;
      end else start = 1'b0;
    end
    check({name, "/finished"}, cycles < 5000, 1);

    // Reference model: expected sequence and expected mismatch outcome.
    exp_err = 0; exp_first = '0; bad = 0;
    for (int i = 0; i < int'(n); i++) begin
      ea = b + ADDR_W'(i);
      ed = DATA_W'(i) ^ s;
      if (i >= wr_a.size() || wr_a[i] !== ea || wr_d[i] !== ed) bad++;
      if (i >= rd_a.size() || rd_a[i] !== ea) bad++;
      if (cen && ea == caddr) begin
        if (exp_err == 0) exp_first = ea;
        exp_err++;
      end
    end
    check({name, "/counts"}, {32'(wr_a.size()), 32'(rd_a.size())}, {32'(n), 32'(n)});
    check({name, "/compares"}, valid_cnt, n);
    check({name, "/sequence_bad"}, bad, 0);
    check({name, "/err_count"}, err_count, exp_err);
    check({name, "/first_err"}, first_err_addr, exp_first);
    check({name, "/status"}, {done, pass, busy}, {1'b1, exp_err == 0, 1'b0});
    check({name, "/protocol_viol"}, stable_viol + overlap_viol + be_viol, 0);
    check({name, "/outstanding_viol"}, maxout_viol, 0);
    check({name, "/early_done"}, early_viol, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cycles;
    logic [ADDR_W-1:0] rb, rn;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; seed = '0;
    repeat (3) @(negedge clk);
    check("reset/cmds", {avm_write, avm_read, avm_address, avm_writedata}, 0);
    check("reset/status", {busy, done, pass, err_count, first_err_addr}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_test("basic", 25'h100, 25'd8, 16'hA5A5, 0, 2, 0, '0, 0);
    check("basic/last_data", (wr_d.size() == 8) ? wr_d[7] : 16'h0, 16'hA5A2);
    run_test("stall", 25'h100, 25'd8, 16'hA5A5, 1, 2, 0, '0, 0);
    run_test("corrupt", 25'h100, 25'd8, 16'hA5A5, 0, 2, 1, 25'h103, 0);
    reset_and_check("reset_in_done");
    run_test("lat10", 25'h100, 25'd8, 16'hA5A5, 0, 10, 0, '0, 1);
    run_test("len0", 25'h100, 25'd0, 16'hA5A5, 0, 2, 0, '0, 0);

    // Wrap-around and reset during READ.
    clear_obs(0, 6, 0, '0);
    pulse_start(25'h1FFFFFE, 25'd4, 16'h1234);
    cycles = 0;
    while (rd_a.size() == 0 && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    check("wrap/reached_read", cycles < 200, 1);
    reset_and_check("reset_in_read");
    check("wrap/addrs", {wr_a.size() == 4 ? wr_a[0] : 25'h0, wr_a.size() == 4 ? wr_a[1] : 25'h0,
                         wr_a.size() == 4 ? wr_a[2] : 25'h5, wr_a.size() == 4 ? wr_a[3] : 25'h5},
                        {25'h1FFFFFE, 25'h1FFFFFF, 25'h0, 25'h1});
    repeat (12) @(negedge clk);
    check("wrap/stale_ignored", {busy, done, err_count, avm_read}, 0);
    run_test("after_reset", 25'h1FFFFFE, 25'd4, 16'h1234, 0, 3, 0, '0, 0);

    // Randomized runs against the same model.
    for (int t = 0; t < 5; t++) begin
      rb = ADDR_W'($urandom);
      rn = ADDR_W'($urandom_range(1, 40));
      run_test($sformatf("rand%0d", t), rb, rn, DATA_W'($urandom), 2, $urandom_range(1, 12),
               1'($urandom_range(0, 1)), rb + ADDR_W'($urandom_range(0, int'(rn) - 1)), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
